// File: rtl/pc_gen.sv
// Program-counter generator: BOOT/RUN/STALL sequencer driving a valid/ready fetch request.
// Optional macro PC_EXC_EN adds the exc_valid port and the EXC_VECTOR redirect.
module pc_gen #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned PC_STEP      = 4,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0380
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  br_valid,
    input  logic [ADDR_WIDTH-1:0] br_target,
`ifdef PC_EXC_EN
    input  logic                  exc_valid,
`endif
    input  logic                  fetch_ready,
    output logic                  fetch_valid,
    output logic [ADDR_WIDTH-1:0] pc
);

    localparam logic [ADDR_WIDTH-1:0] RST_PC  = ADDR_WIDTH'(RESET_VECTOR);
    localparam logic [ADDR_WIDTH-1:0] EXC_PC  = ADDR_WIDTH'(EXC_VECTOR);
    localparam logic [ADDR_WIDTH-1:0] STEP_PC = ADDR_WIDTH'(PC_STEP);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [ADDR_WIDTH-1:0]   pc_d;
    logic                    exc_req;
    logic                    handshake;

    // Exception request is a constant zero when the feature is compiled out.
`ifdef PC_EXC_EN
    assign exc_req = exc_valid;
`else
    assign exc_req = 1'b0;
`endif

    assign handshake = fetch_valid & fetch_ready;

    // Next-state and next-pc: redirects never affect sequencing, only stall does.
    always_comb begin
        state_d = state_q;
        pc_d    = pc;
        case (state_q)
            BOOT:    state_d = stall ? STALL : RUN;
            RUN:     state_d = stall ? STALL : RUN;
            STALL:   state_d = stall ? STALL : RUN;
            default: state_d = BOOT;
        endcase
        if (exc_req) begin
            pc_d = EXC_PC;
        end else if (br_valid) begin
            pc_d = br_target;
        end else if (handshake) begin
            pc_d = pc + STEP_PC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= BOOT;
            pc          <= RST_PC;
            fetch_valid <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc          <= pc_d;
            fetch_valid <= (state_d == RUN);
        end
    end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: width of every address port and of the PC register.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h0000_0000: PC value loaded by reset, truncated to ADDR_WIDTH.
REQ-003 SHALL have parameter PC_STEP, default 4: increment applied per accepted fetch.
REQ-004 SHALL have parameter EXC_VECTOR, default 32'h0000_0380: exception target, used only when PC_EXC_EN is defined.
REQ-005 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port stall, input, 1: the pipeline requests the fetch stream to be frozen.
REQ-008 SHALL have port br_valid, input, 1: branch/jump redirect request.
REQ-009 SHALL have port br_target, input, ADDR_WIDTH: redirect target, sampled when br_valid=1.
REQ-010 SHALL have port exc_valid, input, 1: exception redirect to EXC_VECTOR; present only under PC_EXC_EN.
REQ-011 SHALL have port fetch_ready, input, 1: the fetch unit accepts the current PC.
REQ-012 SHALL have port fetch_valid, output, 1, registered: pc is a valid fetch request.
REQ-013 SHALL have port pc, output, ADDR_WIDTH, registered: current fetch address.

Function
REQ-014 SHALL implement three states: BOOT, RUN, STALL; fetch_valid=1 only in RUN, derived from the state register with no input-to-output combinational path.
REQ-015 BOOT SHALL last exactly one cycle after rst deasserts; next state is STALL if stall=1, else RUN.
REQ-016 RUN SHALL go to STALL when stall=1 at the clock edge; STALL SHALL go to RUN when stall=0 at the clock edge.
REQ-017 A handshake (fetch_valid=1 and fetch_ready=1) with no redirect SHALL load pc with pc+PC_STEP at the edge, modulo 2^ADDR_WIDTH, so the top address wraps to 0.
REQ-018 In RUN without handshake or redirect, pc SHALL hold, and fetch_valid SHALL stay 1 until the handshake.
REQ-019 br_valid=1 SHALL load pc with br_target at the next edge in any state (BOOT, RUN, STALL), regardless of fetch_ready; the unaccepted request is cancelled.
REQ-020 Priority at each edge SHALL be: rst > exc_valid > br_valid > handshake increment > hold.
REQ-021 A redirect during a handshake cycle SHALL win: pc=target, not pc+PC_STEP.
REQ-022 stall=1 together with a handshake in RUN SHALL advance pc per REQ-017 and enter STALL.
REQ-023 stall=1 together with a redirect SHALL load the target and enter or remain in STALL; pc holds the target until the stall releases.
REQ-024 Targets SHALL be loaded unmodified, with no alignment masking.

Reset
REQ-025 rst=1 at an edge SHALL set pc=RESET_VECTOR, fetch_valid=0 and state=BOOT, overriding all other inputs including an in-flight handshake.
REQ-026 rst asserted mid-operation in any state SHALL produce the same result as a power-on reset one cycle later.

Configuration
REQ-027 Macro PC_EXC_EN defined SHALL add the exc_valid port, which at top redirect priority loads EXC_VECTOR at the next edge in any state.
REQ-028 Without PC_EXC_EN, the exc_valid port and the EXC_VECTOR logic SHALL be absent, and branch is the highest-priority redirect.

Verification
REQ-029 Reset release, stall=0, fetch_ready=1 -> cycle 0 fetch_valid=0 pc=0; then pc 0,4,8,12 with fetch_valid=1.
REQ-030 In RUN at pc=0x100, fetch_ready=0 for 3 cycles -> pc stays 0x100 and fetch_valid stays 1; then ready=1 -> 0x104.
REQ-031 Handshake at pc=0x200 with br_valid=1, br_target=0x4000 -> next pc=0x4000, not 0x204.
REQ-032 ADDR_WIDTH=16 at pc=0xFFFC with handshake -> pc=0x0000.
REQ-033 Stall for 2 cycles with br_valid pulse to 0x80 in the first -> fetch_valid=0 during stall, pc=0x80, then RUN issues 0x80.
REQ-034 PC_EXC_EN: exc_valid and br_valid together -> pc=0x380; rst mid-STALL -> pc=RESET_VECTOR, BOOT.
